// File: rtl/raizing_gfx_pkg.sv
// raizing_gfx_pkg: shared channel ids, FSM encoding and default widths for the GFX ROM arbiter
package raizing_gfx_pkg;
  localparam int GFX_AW = 22;
  localparam int GFX_DW = 32;
  localparam logic [1:0] CH_OBJ  = 2'd0;
  localparam logic [1:0] CH_SCR0 = 2'd1;
  localparam logic [1:0] CH_SCR1 = 2'd2;
  localparam logic [1:0] CH_SCR2 = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP} state_e;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/raizing_gfx_arbiter_if.sv
// raizing_gfx_arbiter_if: four fetcher handshakes plus the shared ROM port and debug status
interface raizing_gfx_arbiter_if import raizing_gfx_pkg::*; #(
  parameter int AW = GFX_AW,
  parameter int DW = GFX_DW
);
  logic [3:0]         cs;
  logic [3:0][AW-1:0] addr;
  logic [3:0][DW-1:0] dout;
  logic [3:0]         ok;
  logic               gfx_cs;
  logic [AW-1:0]      gfx_addr;
  logic [DW-1:0]      gfx_dout;
  logic               gfx_ok;
  logic [1:0]         grant;
  logic               busy;
  logic [7:0]         tmo_cnt;
  modport slave (input cs, addr, gfx_dout, gfx_ok, output dout, ok, gfx_cs, gfx_addr, grant, busy, tmo_cnt);
  modport master (output cs, addr, gfx_dout, gfx_ok, input dout, ok, gfx_cs, gfx_addr, grant, busy, tmo_cnt);
endinterface

// File: rtl/raizing_rr_pick.sv
// raizing_rr_pick: combinational 4-way round-robin picker with optional channel-0 override
module raizing_rr_pick import raizing_gfx_pkg::*; (
  input  logic [3:0] pend,
  input  logic [1:0] ptr,
  input  logic       prio0,
  output logic       any,
  output logic [1:0] sel
);
  always_comb begin
    any = |pend;
    sel = ptr;
    // scan from farthest to nearest so the first pending after ptr wins
    for (int i = 4; i >= 1; i--) sel = pend[2'(ptr + 2'(i))] ? 2'(ptr + 2'(i)) : sel;
    sel = (prio0 && pend[CH_OBJ]) ? CH_OBJ : sel;
  end
endmodule

// File: rtl/raizing_gfx_arbiter.sv
// raizing_gfx_arbiter: shares one GFX ROM port between OBJ/SCR0/SCR1/SCR2 with per-channel result caches
module raizing_gfx_arbiter import raizing_gfx_pkg::*; #(
  parameter int AW       = GFX_AW,
  parameter int DW       = GFX_DW,
  parameter bit OBJ_PRIO = 1'b0,
  parameter int OK_BLANK = 1,
  parameter int TIMEOUT  = 255
) (
  input logic CLK,
  input logic RESET,
  raizing_gfx_arbiter_if.slave bus
);
  state_e             state_q, state_d;
  logic               gfx_cs_q, gfx_cs_d;
  logic [AW-1:0]      gfx_addr_q, gfx_addr_d;
  logic [1:0]         grant_q, grant_d, rr_q, rr_d;
  logic [7:0]         cnt_q, cnt_d, tmo_q, tmo_d;
  logic [3:0][AW-1:0] tag_addr_q, tag_addr_d;
  logic [3:0]         tag_valid_q, tag_valid_d;
  logic [3:0][DW-1:0] dout_q, dout_d;
  logic [3:0]         hit, pend;
  logic               any;
  logic [1:0]         sel;
  for (genvar n = 0; n < 4; n++) begin : g_hit
    assign hit[n] = bus.cs[n] & tag_valid_q[n] & (bus.addr[n] == tag_addr_q[n]);
  end
  assign pend = bus.cs & ~hit;
  raizing_rr_pick u_pick (.pend(pend), .ptr(rr_q), .prio0(OBJ_PRIO), .any(any), .sel(sel));
  always_comb begin
    state_d     = state_q;
    gfx_cs_d    = gfx_cs_q;
    gfx_addr_d  = gfx_addr_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    tag_addr_d  = tag_addr_q;
    tag_valid_d = tag_valid_q;
    dout_d      = dout_q;
    case (state_q)
      // the gap cycle already holds GFX_CS low, so it arbitrates like IDLE
      ST_IDLE, ST_GAP: begin
        state_d = ST_IDLE;
        if (any) begin
          grant_d    = sel;
          gfx_addr_d = bus.addr[sel];
          gfx_cs_d   = 1'b1;
          cnt_d      = (OK_BLANK == 0) ? 8'd1 : 8'd0;
          state_d    = (OK_BLANK == 0) ? ST_WAIT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = (cnt_q == 8'(OK_BLANK - 1)) ? 8'd1 : cnt_q + 8'd1;
        state_d = (cnt_q == 8'(OK_BLANK - 1)) ? ST_WAIT : ST_ISSUE;
      end
      default: begin
        if (bus.gfx_ok) begin
          tag_addr_d[grant_q]  = gfx_addr_q;
          tag_valid_d[grant_q] = 1'b1;
          dout_d[grant_q]      = bus.gfx_dout;
          gfx_cs_d             = 1'b0;
          rr_d                 = grant_q;
          state_d              = ST_GAP;
        end else if (TIMEOUT != 0 && cnt_q == 8'(TIMEOUT)) begin
          gfx_cs_d = 1'b0;
          tmo_d    = sat_inc8(tmo_q);
          state_d  = ST_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      gfx_cs_q    <= 1'b0;
      gfx_addr_q  <= '0;
      grant_q     <= CH_OBJ;
      rr_q        <= CH_SCR2;
      cnt_q       <= '0;
      tmo_q       <= '0;
      tag_addr_q  <= '0;
      tag_valid_q <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      gfx_cs_q    <= gfx_cs_d;
      gfx_addr_q  <= gfx_addr_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      tag_addr_q  <= tag_addr_d;
      tag_valid_q <= tag_valid_d;
      dout_q      <= dout_d;
    end
  end
  assign bus.ok       = hit;
  assign bus.dout     = dout_q;
  assign bus.gfx_cs   = gfx_cs_q;
  assign bus.gfx_addr = gfx_addr_q;
  assign bus.grant    = grant_q;
  assign bus.busy     = state_q != ST_IDLE;
  assign bus.tmo_cnt  = tmo_q;
endmodule
